midi_receiver: RTL and testbench

MIDI_RECEIVER -- requirements
Module: midi_receiver

---
 rtl/midi_pkg.sv | 31 +++
 rtl/uart_rx_byte.sv | 115 +++++++++++
 rtl/midi_receiver.sv | 109 ++++++++++
 tb/tb_midi_receiver.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI note-on receiver.
package midi_pkg;

  // Serial byte framer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Note-on parser states.
  typedef enum logic [1:0] {
    WAIT_STATUS = 2'd0,
    WAIT_NOTE   = 2'd1,
    WAIT_VEL    = 2'd2
  } parser_state_t;

  localparam logic [3:0] NOTE_ON        = 4'h9;
  localparam logic [7:0] SYS_COMMON_MIN = 8'hF0;
  localparam logic [7:0] REALTIME_MIN   = 8'hF8;

  // Width of the bit-period counter; supports up to 4095 clocks per bit.
  localparam int BAUD_CNT_W = 12;

  // Clocks per serial bit, truncated toward zero.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Synchronizes the MIDI line and frames 8N1 bytes; emits one-cycle
// byte_valid / frame_err pulses at the end of each frame.
module uart_rx_byte
  import midi_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2080
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       midi_in,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam logic [BAUD_CNT_W-1:0] FULL_CNT = BAUD_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_CNT_W-1:0] HALF_CNT = BAUD_CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic                  sync1_reg, sync2_reg, prev_reg;
  uart_state_t           state_reg, state_next;
  logic [BAUD_CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]            bit_idx_reg, bit_idx_next;
  logic [7:0]            shift_reg, shift_next;
  logic                  valid_reg, valid_next;
  logic                  ferr_reg, ferr_next;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
    end else begin
      sync1_reg <= midi_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  // Framer state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      valid_reg   <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      valid_reg   <= valid_next;
      ferr_reg    <= ferr_next;
    end
  end

  // Framer next-state: half-bit start check, 8 LSB-first samples, stop check.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    valid_next   = 1'b0;
    ferr_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (prev_reg && !sync2_reg) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (cnt_reg == HALF_CNT) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          // A line that is high again at mid-start was a glitch.
          state_next   = sync2_reg ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (cnt_reg == FULL_CNT) begin
          cnt_next   = '0;
          shift_next = {sync2_reg, shift_reg[7:1]};
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      STOP: begin
        if (cnt_reg == FULL_CNT) begin
          cnt_next   = '0;
          state_next = IDLE;
          valid_next = sync2_reg;
          ferr_next  = !sync2_reg;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign data_byte  = shift_reg;
  assign byte_valid = valid_reg;
  assign frame_err  = ferr_reg;

endmodule

// File: rtl/midi_receiver.sv
// MIDI note-on receiver: frames bytes from the serial line and extracts
// note-on events (with running status), presenting note and velocity.
module midi_receiver
  import midi_pkg::*;
#(
  parameter int CLK_HZ = 65000000,
  parameter int BAUD   = 31250
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       midi_in,
  output logic [6:0] midi_index,
  output logic [6:0] midi_velocity,
  output logic       midi_ready,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

  logic [7:0]    rx_byte;
  logic          rx_valid;

  parser_state_t pstate_reg, pstate_next;
  logic [3:0]    running_status_reg, running_status_next;
  logic [6:0]    note_reg, note_next;
  logic [6:0]    index_reg, index_next;
  logic [6:0]    velocity_reg, velocity_next;
  logic          ready_reg, ready_next;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock     (clock),
    .reset     (reset),
    .midi_in   (midi_in),
    .data_byte (rx_byte),
    .byte_valid(rx_valid),
    .frame_err (frame_err)
  );

  // Parser state and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pstate_reg         <= WAIT_STATUS;
      running_status_reg <= '0;
      note_reg           <= '0;
      index_reg          <= '0;
      velocity_reg       <= '0;
      ready_reg          <= 1'b0;
    end else begin
      pstate_reg         <= pstate_next;
      running_status_reg <= running_status_next;
      note_reg           <= note_next;
      index_reg          <= index_next;
      velocity_reg       <= velocity_next;
      ready_reg          <= ready_next;
    end
  end

  // Parser next-state: classify each delivered byte and track note-on pairs.
  always_comb begin
    pstate_next         = pstate_reg;
    running_status_next = running_status_reg;
    note_next           = note_reg;
    index_next          = index_reg;
    velocity_next       = velocity_reg;
    ready_next          = 1'b0;
    if (rx_valid) begin
      if (rx_byte >= REALTIME_MIN) begin
        // Realtime messages interleave anywhere and are transparent.
        pstate_next = pstate_reg;
      end else if (rx_byte >= SYS_COMMON_MIN) begin
        running_status_next = '0;
        pstate_next         = WAIT_STATUS;
      end else if (rx_byte[7]) begin
        running_status_next = rx_byte[7:4];
        pstate_next         = (rx_byte[7:4] == NOTE_ON) ? WAIT_NOTE : WAIT_STATUS;
      end else begin
        case (pstate_reg)
          WAIT_NOTE: begin
            note_next   = rx_byte[6:0];
            pstate_next = WAIT_VEL;
          end
          WAIT_STATUS: begin
            if (running_status_reg == NOTE_ON) begin
              note_next   = rx_byte[6:0];
              pstate_next = WAIT_VEL;
            end
          end
          WAIT_VEL: begin
            pstate_next = WAIT_NOTE;
            // Velocity zero is a note-off in disguise: no event.
            if (rx_byte[6:0] != 7'd0) begin
              index_next    = note_reg;
              velocity_next = rx_byte[6:0];
              ready_next    = 1'b1;
            end
          end
          default: pstate_next = WAIT_STATUS;
        endcase
      end
    end
  end

  assign midi_index    = index_reg;
  assign midi_velocity = velocity_reg;
  assign midi_ready    = ready_reg;

endmodule

// File: tb/tb_midi_receiver.sv
// Self-checking bench for midi_receiver: directed vector table, a mid-byte
// reset sequence, and a randomized byte stream against a message-level model.
module tb_midi_receiver;

  localparam int CLK_HZ = 1600;
  localparam int BAUD   = 100;
  localparam int CPB    = CLK_HZ / BAUD;

  logic       clock;
  logic       reset;
  logic       midi_in;
  logic [6:0] midi_index;
  logic [6:0] midi_velocity;
  logic       midi_ready;
  logic       frame_err;

  midi_receiver #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .midi_in      (midi_in),
    .midi_index   (midi_index),
    .midi_velocity(midi_velocity),
    .midi_ready   (midi_ready),
    .frame_err    (frame_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Observations collected on the falling edge.
  int pulse_cnt  = 0;
  int ferr_cnt   = 0;
  int double_cnt = 0;
  int obs_q[$];
  logic prev_ready = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      prev_ready = 1'b0;
    end else begin
      if (midi_ready) begin
        pulse_cnt++;
        obs_q.push_back(int'(midi_index) * 256 + int'(midi_velocity));
        if (prev_ready) double_cnt++;
      end
      if (frame_err) ferr_cnt++;
      prev_ready = midi_ready;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int cycles);
    midi_in = v;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    drive_bit(good_stop, CPB);
    drive_bit(1'b1, 2 * CPB);
  endtask

  task automatic apply_reset();
    midi_in = 1'b1;
    reset   = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  // Message-level model: a running status and an optional pending note.
  int m_rs;
  int m_pending;
  int exp_q[$];

  task automatic model_byte(input int b);
    if (b >= 'hF8) return;
    if (b >= 'hF0) begin
      m_rs = 0; m_pending = -1;
    end else if (b >= 'h80) begin
      m_rs = b / 16; m_pending = -1;
    end else if (m_pending >= 0) begin
      if (b != 0) exp_q.push_back(m_pending * 256 + b);
      m_pending = -1;
    end else if (m_rs == 9) begin
      m_pending = b;
    end
  endtask

  typedef struct {
    bit          do_reset;
    int          n;
    logic [63:0] bytes;      // first byte in the top octet
    logic [7:0]  bad_mask;   // bit i set: byte i sent with stop bit 0
    int          exp_pulses;
    int          exp_index;
    int          exp_vel;
    int          exp_ferr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [63:0] bs;
    int p0, f0, nbad;

    vecs[0] = '{1'b1, 3, 64'h90_3C_64_00_00_00_00_00, 8'h00, 1, 60, 100, 0};
    vecs[1] = '{1'b0, 3, 64'h90_3C_00_00_00_00_00_00, 8'h00, 0, 60, 100, 0};
    vecs[2] = '{1'b1, 5, 64'h93_3C_64_40_50_00_00_00, 8'h00, 2, 64, 80, 0};
    vecs[3] = '{1'b1, 4, 64'h90_3C_F8_64_00_00_00_00, 8'h00, 1, 60, 100, 0};
    vecs[4] = '{1'b1, 3, 64'h90_3C_64_00_00_00_00_00, 8'h01, 0, 0, 0, 1};
    vecs[5] = '{1'b1, 3, 64'h80_3C_64_00_00_00_00_00, 8'h00, 0, 0, 0, 0};
    vecs[6] = '{1'b1, 6, 64'h9F_10_01_F0_20_30_00_00, 8'h00, 1, 16, 1, 0};
    vecs[7] = '{1'b0, 6, 64'h95_7F_7F_FA_11_22_00_00, 8'h00, 2, 17, 34, 0};
    vecs[8] = '{1'b1, 8, 64'hB0_07_64_90_01_00_02_03, 8'h00, 1, 2, 3, 0};

    // Outputs while reset is held.
    midi_in = 1'b1;
    reset   = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_index", int'(midi_index), 0);
    check("rst_velocity", int'(midi_velocity), 0);
    check("rst_ready", int'(midi_ready), 0);
    check("rst_frame_err", int'(frame_err), 0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // Directed vector table.
    for (int v = 0; v < 9; v++) begin
      if (vecs[v].do_reset) apply_reset();
      p0 = pulse_cnt;
      f0 = ferr_cnt;
      bs = vecs[v].bytes;
      for (int i = 0; i < vecs[v].n; i++)
        send_byte(bs[63 - 8*i -: 8], !vecs[v].bad_mask[i]);
      repeat (CPB) @(negedge clock);
      $display("vec %0d: pulses=%0d index=%0d velocity=%0d frame_errs=%0d",
               v, pulse_cnt - p0, midi_index, midi_velocity, ferr_cnt - f0);
      check($sformatf("vec%0d_pulses", v), pulse_cnt - p0, vecs[v].exp_pulses);
      check($sformatf("vec%0d_index", v), int'(midi_index), vecs[v].exp_index);
      check($sformatf("vec%0d_velocity", v), int'(midi_velocity), vecs[v].exp_vel);
      check($sformatf("vec%0d_frame_err", v), ferr_cnt - f0, vecs[v].exp_ferr);
    end

    // Reset in the middle of a note byte.
    apply_reset();
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h64, 1'b1);
    check("pre_reset_index", int'(midi_index), 60);
    send_byte(8'h90, 1'b1);
    bs[7:0] = 8'h3C;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(bs[i], CPB);
    drive_bit(bs[4], CPB / 2);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_index", int'(midi_index), 0);
    check("midrst_velocity", int'(midi_velocity), 0);
    check("midrst_ready", int'(midi_ready), 0);
    p0 = pulse_cnt;
    drive_bit(bs[4], CPB / 2 - 1);
    for (int i = 5; i < 8; i++) drive_bit(bs[i], CPB);
    drive_bit(1'b1, 20 * CPB);
    check("midrst_tail_pulses", pulse_cnt - p0, 0);
    send_byte(8'h90, 1'b1);
    send_byte(8'h45, 1'b1);
    send_byte(8'h7F, 1'b1);
    repeat (CPB) @(negedge clock);
    $display("midreset: pulses=%0d index=%0d velocity=%0d",
             pulse_cnt - p0, midi_index, midi_velocity);
    check("midrst_pulses", pulse_cnt - p0, 1);
    check("midrst_new_index", int'(midi_index), 69);
    check("midrst_new_velocity", int'(midi_velocity), 127);

    // Randomized byte stream against the model.
    apply_reset();
    m_rs = 0;
    m_pending = -1;
    exp_q.delete();
    obs_q.delete();
    f0 = ferr_cnt;
    nbad = 0;
    for (int k = 0; k < 80; k++) begin
      int cat, b;
      cat = int'($urandom_range(0, 9));
      case (cat)
        0, 1, 2: b = 'h90 + int'($urandom_range(0, 15));
        3, 4, 5: b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 127));
        6:       b = 'h80 + int'($urandom_range(0, 'h6F));
        7:       b = 'hF8 + int'($urandom_range(0, 7));
        8:       b = 'hF0 + int'($urandom_range(0, 7));
        default: b = int'($urandom_range(0, 255));
      endcase
      if (cat == 9) begin
        nbad++;
        send_byte(8'(b), 1'b0);
      end else begin
        model_byte(b);
        send_byte(8'(b), 1'b1);
      end
    end
    repeat (CPB) @(negedge clock);
    check("rand_event_count", obs_q.size(), exp_q.size());
    check("rand_frame_err", ferr_cnt - f0, nbad);
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      $display("rand event %0d: got index=%0d velocity=%0d, expected index=%0d velocity=%0d",
               i, obs_q[i] / 256, obs_q[i] % 256, exp_q[i] / 256, exp_q[i] % 256);
      check($sformatf("rand_event%0d", i), obs_q[i], exp_q[i]);
    end

    check("ready_single_cycle", double_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
